// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic cells (subtractor now,
// serial adder later). Holds the common three-state sequencing encoding.
package serial_arith_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } serial_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
// Gate-level, mirroring the full-adder cell of the arithmetic library.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic axb;
  logic b_gt_a;
  logic eq_bin;

  xor g_axb  (axb, a, b);
  xor g_d    (d, axb, bin);
  and g_bgta (b_gt_a, ~a, b);
  and g_eqb  (eq_bin, ~axb, bin);
  or  g_bout (bout, b_gt_a, eq_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clk.
// A WIDTH-bit result is produced every WIDTH+1 cycles.
// Optional build macro SERIAL_SUBTRACTOR_OVF_EN adds the signed overflow
// flag; without it ovf is tied low and no overflow logic exists.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; operands loaded when start is seen
// SHIFT  | one bit per cycle through the cell, cnt counts bits done
// DONE   | result valid (done high); start here reloads back-to-back
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  serial_state_e    state;
  serial_state_e    state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Only WIDTH-1 partial bits are kept; the last bit goes straight to diff.
  logic [WIDTH-2:0] p_sh;
  logic [WIDTH-1:0] p_nx;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             d;
  logic             bout;
  logic             load;
  logic             last;
  logic             busy_q;
  logic             done_q;

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bin),
    .d    (d),
    .bout (bout)
  );

  assign p_nx = {d, p_sh};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode plus operand-load and final-bit strobes.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    last     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt == CNT_LAST) begin
          last     = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = S_SHIFT;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // busy/done registered from next state so they are clean flop outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nx == S_SHIFT);
      done_q <= (state_nx == S_DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // Operand shift registers, borrow flop, partial result and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      p_sh <= '0;
      bin  <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      a_sh <= a;
      b_sh <= b;
      bin  <= 1'b0;
      cnt  <= '0;
    end else if (state == S_SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      p_sh <= p_nx[WIDTH-1:1];
      bin  <= bout;
      cnt  <= cnt + 1'b1;
    end
  end

  // Result registers change only when the MSB step completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff   <= '0;
      borrow <= 1'b0;
    end else if (last) begin
      diff   <= p_nx;
      borrow <= bout;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf_q;

  // Signed overflow: borrow into the MSB differs from borrow out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (last) begin
      ovf_q <= bin ^ bout;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

  int n_cmp;
  int n_err;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  localparam logic OVF_80_01 = 1'b1;
`else
  localparam logic OVF_80_01 = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start, then count busy cycles until done (bounded).
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int busy_cyc, output logic got_done);
    a = av;
    b = bv;
    start = 1'b1;
    step();
    start = 1'b0;
    busy_cyc = 0;
    got_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
      step();
    end
  endtask

  task automatic op_check(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
    int bc;
    logic gd;
    run_op(av, bv, bc, gd);
    check({tag, "_done"}, 32'(gd), 32'd1);
    check({tag, "_busycyc"}, 32'(bc), 32'd8);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_borrow"}, 32'(borrow), 32'(eb));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    check({tag, "_nobusy"}, 32'(busy), 32'd0);
    step();
    check({tag, "_donepulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int gap;
    int bc;
    logic gd;
    logic seen;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    op_check("t05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    op_check("t03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    op_check("t80_01", 8'h80, 8'h01, 8'h7F, 1'b0, OVF_80_01);
    op_check("t7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, OVF_80_01);

    // Result holds while idle.
    step();
    step();
    check("hold_diff", 32'(diff), 32'h80);

    // Back-to-back: start held, new operands presented during DONE.
    a = 8'h00;
    b = 8'h00;
    start = 1'b1;
    step();
    a = 8'hFF;
    b = 8'h01;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check("b2b_done1", 32'(seen), 32'd1);
    check("b2b_diff1", 32'(diff), 32'h00);
    step();
    start = 1'b0;
    check("b2b_nogap_busy", 32'(busy), 32'd1);
    gap = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      step();
      gap++;
    end
    check("b2b_done2", 32'(seen), 32'd1);
    check("b2b_gap", 32'(gap), 32'd9);
    check("b2b_diff2", 32'(diff), 32'hFE);
    check("b2b_borrow2", 32'(borrow), 32'd0);
    step();

    // Start during SHIFT is ignored.
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    a = 8'h55;
    b = 8'h22;
    start = 1'b1;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check("ign_done", 32'(seen), 32'd1);
    check("ign_diff", 32'(diff), 32'h0F);
    step();
    check("ign_no_extra_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-operation (diff currently 0x0F).
    a = 8'hC3;
    b = 8'h3C;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_borrow", 32'(borrow), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    check("arst_no_done", 32'(seen), 32'd0);
    run_op(8'h09, 8'h04, bc, gd);
    check("post_rst_done", 32'(gd), 32'd1);
    check("post_rst_busycyc", 32'(bc), 32'd8);
    check("post_rst_diff", 32'(diff), 32'h05);
    check("post_rst_borrow", 32'(borrow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
